// File: rtl/nfc_pkg.sv
// Shared NFC definitions: flash command codes, page geometry, strobe timing defaults and
// the page-reader state encoding. Used by both the flash-A reader and the flash-B program stage.
package nfc_pkg;

  localparam logic [7:0] CMD_READ0 = 8'h00;

  localparam int unsigned PAGE_BYTES = 512;
  localparam int unsigned PAGE_AW    = 9;
  localparam int unsigned BYTE_W     = $clog2(PAGE_BYTES);

  // Strobe timing in clock cycles
  localparam int unsigned WE_LOW  = 1;
  localparam int unsigned WE_HIGH = 1;
  localparam int unsigned RE_LOW  = 2;
  localparam int unsigned RE_HIGH = 1;
  localparam int unsigned WB_CYC  = 8;
  localparam int unsigned TMO_CYC = 4096;

  localparam int unsigned TMR_W = 4;
  localparam int unsigned WB_W  = (WB_CYC > 1) ? $clog2(WB_CYC) : 1;
  localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWaitWb,
    StWaitRb,
    StRead,
    StDone
  } nfc_state_e;

  // Address cycle byte for a small-page read: column, page low byte, page high bit
  function automatic logic [7:0] addr_byte(input logic [1:0] slot,
                                           input logic [PAGE_AW-1:0] pg);
    logic [7:0] b;
    case (slot)
      2'd0:    b = 8'h00;
      2'd1:    b = pg[7:0];
      default: b = {7'b0, pg[8]};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nand_strobe_gen.sv
// Loadable low/high cycle timer. Drives one active-low strobe (WEN or REN) and flags the
// last low cycle (sample) and last high cycle (slot_end). A load during slot_end chains
// pulses back to back with no idle gap.
module nand_strobe_gen
  import nfc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] low_cyc,   // low-phase length minus one
  input  logic [TMR_W-1:0] high_cyc,  // high-phase length minus one
  output logic             strobe_n,
  output logic             sample,
  output logic             slot_end,
  output logic             idle
);

  typedef enum logic [1:0] {PhIdle, PhLow, PhHigh} phase_e;

  phase_e           phase_q, phase_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  assign strobe_n = strobe_q;

  // Phase sequencing and strobe next-state
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    sample   = (phase_q == PhLow) && (cnt_q == '0);
    slot_end = (phase_q == PhHigh) && (cnt_q == '0);
    idle     = (phase_q == PhIdle);
    unique case (phase_q)
      PhLow: begin
        if (cnt_q == '0) begin
          phase_d  = PhHigh;
          cnt_d    = high_cyc;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - TMR_W'(1);
        end
      end
      PhHigh: begin
        if (cnt_q == '0) phase_d = PhIdle;
        else             cnt_d   = cnt_q - TMR_W'(1);
      end
      default: ;
    endcase
    if (load && (idle || slot_end)) begin
      phase_d  = PhLow;
      cnt_d    = low_cyc;
      strobe_d = 1'b0;
    end
  end

  // Timer state, strobe idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PhIdle;
      cnt_q    <= '0;
      strobe_q <= 1'b1;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

endmodule

// File: rtl/nand_page_reader.sv
// Flash-A page reader: issues READ0 + 3 address cycles, waits tWB and R/B, then streams
// PAGE_BYTES bytes over a valid/ready handshake with at most one byte in flight.
// Optional R/B watchdog enabled by defining NFC_RB_TIMEOUT_EN.
module nand_page_reader
  import nfc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [PAGE_AW-1:0] page,
  output logic               busy,
  output logic               page_done,
  output logic [7:0]         dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               err,
  input  logic [7:0]         f_io_in,
  output logic [7:0]         f_io_out,
  output logic               f_io_oe,
  output logic               F_CLE_A,
  output logic               F_ALE_A,
  output logic               F_WEN_A,
  output logic               F_REN_A,
  input  logic               F_RB_A
);

  nfc_state_e         state_q, state_d;
  logic [PAGE_AW-1:0] page_q, page_d;
  logic [1:0]         slot_q, slot_d;
  logic [WB_W-1:0]    wb_cnt_q, wb_cnt_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               dout_last_q, dout_last_d;

  logic             sg_load, sg_strobe_n, sg_sample, sg_slot_end, sg_idle;
  logic             rd_phase, hs;
  logic [TMR_W-1:0] sg_low, sg_high;

`ifdef NFC_RB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Read timing applies from the load in WAIT_RB onward; otherwise write-slot timing
  assign rd_phase = (state_q == StWaitRb) || (state_q == StRead);
  assign sg_low   = rd_phase ? TMR_W'(RE_LOW - 1)  : TMR_W'(WE_LOW - 1);
  assign sg_high  = rd_phase ? TMR_W'(RE_HIGH - 1) : TMR_W'(WE_HIGH - 1);

  nand_strobe_gen u_strobe (
    .clk      (clk),
    .rst      (rst),
    .load     (sg_load),
    .low_cyc  (sg_low),
    .high_cyc (sg_high),
    .strobe_n (sg_strobe_n),
    .sample   (sg_sample),
    .slot_end (sg_slot_end),
    .idle     (sg_idle)
  );

  assign hs = dout_valid_q && dout_ready;

  // Flash pins decode from state; all sources are reset registers so pins drop immediately
  assign F_CLE_A    = (state_q == StCmd);
  assign F_ALE_A    = (state_q == StAddr);
  assign f_io_oe    = F_CLE_A || F_ALE_A;
  assign f_io_out   = F_CLE_A ? CMD_READ0 : (F_ALE_A ? addr_byte(slot_q, page_q) : 8'h00);
  assign F_WEN_A    = f_io_oe ? sg_strobe_n : 1'b1;
  assign F_REN_A    = (state_q == StRead) ? sg_strobe_n : 1'b1;
  assign busy       = (state_q != StIdle);
  assign page_done  = (state_q == StDone);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

  // Next-state: command/address slots, tWB, R/B wait, byte streaming
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    slot_d       = slot_q;
    wb_cnt_d     = wb_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    sg_load      = 1'b0;
`ifdef NFC_RB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
`endif

    if (hs) begin
      dout_valid_d = 1'b0;
      dout_last_d  = 1'b0;
      byte_cnt_d   = byte_cnt_q + BYTE_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          page_d     = page;
          slot_d     = 2'd0;
          byte_cnt_d = '0;
          sg_load    = 1'b1;
          state_d    = StCmd;
        end
      end
      StCmd: begin
        if (sg_slot_end) begin
          slot_d  = 2'd0;
          sg_load = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (sg_slot_end) begin
          if (slot_q == 2'd2) begin
            wb_cnt_d = '0;
            state_d  = StWaitWb;
          end else begin
            slot_d  = slot_q + 2'd1;
            sg_load = 1'b1;
          end
        end
      end
      StWaitWb: begin
        if (wb_cnt_q == WB_W'(WB_CYC - 1)) begin
          state_d = StWaitRb;
`ifdef NFC_RB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          wb_cnt_d = wb_cnt_q + WB_W'(1);
        end
      end
      StWaitRb: begin
        if (F_RB_A) begin
          sg_load = 1'b1;
          state_d = StRead;
        end
`ifdef NFC_RB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      StRead: begin
        // No byte is outstanding while a pulse is low, so byte_cnt_q indexes this byte
        if (sg_sample) begin
          dout_d       = f_io_in;
          dout_valid_d = 1'b1;
          dout_last_d  = (byte_cnt_q == BYTE_W'(PAGE_BYTES - 1));
        end
        if (hs && dout_last_q) begin
          state_d = StDone;
        end else if ((sg_idle || sg_slot_end) && (!dout_valid_q || hs)) begin
          sg_load = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Controller and output-byte registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      page_q       <= '0;
      slot_q       <= '0;
      wb_cnt_q     <= '0;
      byte_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      slot_q       <= slot_d;
      wb_cnt_q     <= wb_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

`ifdef NFC_RB_TIMEOUT_EN
  // R/B watchdog counter and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_nand_page_reader.sv
// Scoreboard bench for nand_page_reader with a behavioural small-page flash-A model.
// Timeout scenario is compiled only when NFC_RB_TIMEOUT_EN is defined.
module tb_nand_page_reader;
  import nfc_pkg::*;

  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, dout_ready = 1'b0;
  logic [8:0] page = '0;
  logic       busy, page_done, dout_valid, dout_last, err, f_io_oe;
  logic [7:0] dout, f_io_in, f_io_out;
  logic       F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, F_RB_A;

  nand_page_reader dut (
    .clk(clk), .rst(rst), .start(start), .page(page), .busy(busy), .page_done(page_done),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .err(err), .f_io_in(f_io_in), .f_io_out(f_io_out), .f_io_oe(f_io_oe),
    .F_CLE_A(F_CLE_A), .F_ALE_A(F_ALE_A), .F_WEN_A(F_WEN_A), .F_REN_A(F_REN_A),
    .F_RB_A(F_RB_A)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_unexp(string name, logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h want nothing (cycle %0d)", name, act, cyc);
  endfunction

  // Flash-A page contents
  function automatic logic [7:0] page_byte(input logic [8:0] p, input int c);
    return 8'(c + 3 * int'(p) + ((c >= 256) ? 8'h55 : 0));
  endfunction

  // Flash-A model state
  logic [8:0] fl_page = '0;
  int         fl_col = 0, fl_aidx = 0, rb_busy = 0;
  logic       rb_stuck = 1'b0;
  logic       prev_wen = 1'b1, prev_ren = 1'b1;
  assign f_io_in = page_byte(fl_page, fl_col);
  assign F_RB_A  = !rb_stuck && (rb_busy == 0);

  // Scoreboard
  logic [10:0] lat_exp[$];   // {oe, cle, ale, io}
  logic [8:0]  byte_exp[$];  // {last, data}
  int done_exp = 0, done_seen = 0, hs_count = 0, ren_pulses = 0;
  int last_hs_cyc = -1, addr_cyc = 0, done_cyc = 0;
  bit chk_spacing = 0, rand_ready = 0;
  logic ready_level = 1'b1;

  // Monitor: pin latches, flash model, byte handshakes, page_done
  always @(negedge clk) begin
    if (rst) begin
      if (!prev_wen && F_WEN_A) begin
        if (lat_exp.size() == 0) fail_unexp("latch_spurious", {F_CLE_A, F_ALE_A, f_io_out});
        else check("latch", {f_io_oe, F_CLE_A, F_ALE_A, f_io_out}, lat_exp.pop_front());
        if (F_CLE_A && f_io_out == 8'h00) begin
          fl_aidx = 0;
          fl_col  = 0;
        end else if (F_ALE_A) begin
          case (fl_aidx)
            0: fl_col = int'(f_io_out);
            1: fl_page[7:0] = f_io_out;
            default: begin
              fl_page[8] = f_io_out[0];
              rb_busy    = 20;
              addr_cyc   = cyc;
            end
          endcase
          fl_aidx++;
        end
      end
      if (!prev_ren && F_REN_A) begin
        fl_col++;
        ren_pulses++;
      end
      if (rb_busy > 0) rb_busy--;
      if (dout_valid) begin
        if (byte_exp.size() == 0) fail_unexp("byte_spurious", {dout_last, dout});
        else if (dout_ready) begin
          check("byte", {dout_last, dout}, byte_exp.pop_front());
          if (chk_spacing && last_hs_cyc >= 0) check("spacing", cyc - last_hs_cyc, 3);
          last_hs_cyc = cyc;
          hs_count++;
        end else begin
          check("stall_hold", {dout_last, dout}, byte_exp[0]);
        end
      end
      if (page_done) begin
        check("page_done_expected", done_exp > 0, 1);
        if (done_exp > 0) done_exp--;
        done_seen++;
        done_cyc = cyc;
      end
    end
    prev_wen = F_WEN_A;
    prev_ren = F_REN_A;
  end

  // Consumer ready driver
  initial forever begin
    @(posedge clk);
    #1;
    dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  task automatic do_start(input logic [8:0] p, input bit accept, input bit with_bytes);
    if (accept) begin
      lat_exp.push_back({3'b110, 8'h00});
      lat_exp.push_back({3'b101, 8'h00});
      lat_exp.push_back({3'b101, p[7:0]});
      lat_exp.push_back({3'b101, 7'b0, p[8]});
      if (with_bytes)
        for (int i = 0; i < PAGE_BYTES; i++)
          byte_exp.push_back({(i == PAGE_BYTES - 1), page_byte(p, i)});
      done_exp++;
      hs_count    = 0;
      ren_pulses  = 0;
      last_hs_cyc = -1;
    end
    @(posedge clk);
    #1;
    page  = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int t = 0;
    while (done_seen < target && t < bound) begin
      @(posedge clk);
      t++;
    end
    check("done_within_bound", done_seen >= target, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_pins(input string name);
    check({name, "_ctl"}, {F_CLE_A, F_ALE_A, F_WEN_A, F_REN_A, f_io_oe}, 5'b00110);
    check({name, "_io"}, f_io_out, 8'h00);
    check({name, "_stat"}, {busy, page_done, dout_valid, dout_last, err}, 5'b0);
    check({name, "_dout"}, dout, 8'h00);
  endtask

  task automatic check_drained(input string name);
    check({name, "_bytes_left"}, byte_exp.size(), 0);
    check({name, "_latch_left"}, lat_exp.size(), 0);
    check({name, "_done_left"}, done_exp, 0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Page 0x1A3, consumer always ready: 3-cycle spacing, 512 REN pulses
    chk_spacing = 1;
    do_start(9'h1A3, 1, 1);
    check("busy_after_start", busy, 1);
    wait_done(1, 6000);
    check("t1_hs_count", hs_count, PAGE_BYTES);
    check("t1_ren_pulses", ren_pulses, PAGE_BYTES);
    check("t1_idle", busy, 0);
    check_drained("t1");
    chk_spacing = 0;

    // Random back-pressure
    rand_ready = 1;
    do_start(9'h0C4, 1, 1);
    wait_done(2, 12000);
    check("t2_hs_count", hs_count, PAGE_BYTES);
    check_drained("t2");
    rand_ready = 0;

    // start while busy is ignored
    do_start(9'h07F, 1, 1);
    repeat (200) @(posedge clk);
    do_start(9'h155, 0, 0);
    wait_done(3, 6000);
    check("t3_hs_count", hs_count, PAGE_BYTES);
    repeat (20) @(posedge clk);
    check("t3_single_done", done_seen, 3);
    check_drained("t3");

    // Asynchronous reset after byte 100 is accepted, then page 0
    do_start(9'h1FF, 1, 1);
    t = 0;
    while (hs_count < 101 && t < 6000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("t4_reached_byte100", hs_count >= 101, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_pins("midreset");
    byte_exp.delete();
    lat_exp.delete();
    done_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    do_start(9'h000, 1, 1);
    wait_done(4, 6000);
    check("t4_hs_count", hs_count, PAGE_BYTES);
    check_drained("t4");

`ifdef NFC_RB_TIMEOUT_EN
    // R/B stuck busy: watchdog ends the page with no bytes
    rb_stuck = 1'b1;
    do_start(9'h005, 1, 0);
    wait_done(5, TMO_CYC + 2000);
    check("tmo_err", err, 1);
    check("tmo_latency_ok", (done_cyc - addr_cyc >= int'(TMO_CYC + WB_CYC)) &&
                            (done_cyc - addr_cyc <= int'(TMO_CYC + WB_CYC + 2)), 1);
    check("tmo_no_bytes", hs_count, 0);
    check_drained("tmo");
    rb_stuck = 1'b0;
`else
    check("err_tied_low", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
